// File: rtl/bcd_accumulator.sv
// bcd_accumulator
// Two-digit BCD running-sum stage that feeds the HEX display decoders.
// Each accepted rising edge on Load adds the BCD operand A plus Cin to a
// stored 00..99 total. The add is digit-serial: the ones digit updates one
// cycle after acceptance and the tens digit one cycle after that.
//
// Ports:
//   Clock  in   system clock, rising edge
//   Reset  in   asynchronous active-high reset
//   Load   in   add request, level; a rising edge requests one add
//   Clear  in   synchronous active-high clear of total and sticky flags
//   A      in   [3:0] BCD operand (0..9)
//   Cin    in   carry-in added together with A
//   Q1     out  [3:0] tens digit of the total (BCD)
//   Q0     out  [3:0] ones digit of the total (BCD)
//   Busy   out  high while an add is in progress
//   Ovf    out  sticky, set when the total wraps past 99
//   Err    out  sticky, set when an add is requested with A > 9
//
// Optional build macro BCD_ACC_SYNC_IN_EN: when defined, Load and Clear each
// pass through a two-flop synchronizer before use. This adds two cycles of
// latency. A and Cin are not synchronized.

module bcd_accumulator (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Load,
  input  logic       Clear,
  input  logic [3:0] A,
  input  logic       Cin,
  output logic [3:0] Q1,
  output logic [3:0] Q0,
  output logic       Busy,
  output logic       Ovf,
  output logic       Err
);

  localparam int unsigned DW = 4;        // one BCD digit
  localparam int unsigned SW = DW + 1;   // digit sum incl. carry, max 19
  localparam int unsigned SYNC_W = 2;    // synchronizer depth

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ADD_ONES = 2'd1,
    ADD_TENS = 2'd2
  } state_t;

  state_t        state;
  logic          load_use;
  logic          clear_use;
  logic          load_q;
  logic          request;
  logic [DW-1:0] a_q;
  logic          cin_q;
  logic          carry_q;
  logic [SW-1:0] ones_sum;
  logic [SW-1:0] tens_sum;

`ifdef BCD_ACC_SYNC_IN_EN
  logic [SYNC_W-1:0] load_sync;
  logic [SYNC_W-1:0] clear_sync;

  // Two-flop synchronizers for the key-driven control inputs
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      load_sync  <= '0;
      clear_sync <= '0;
    end else begin
      load_sync  <= {load_sync[0], Load};
      clear_sync <= {clear_sync[0], Clear};
    end
  end

  assign load_use  = load_sync[SYNC_W-1];
  assign clear_use = clear_sync[SYNC_W-1];
`else
  assign load_use  = Load;
  assign clear_use = Clear;
`endif

  // One add per rising edge of the (possibly synchronized) Load level
  assign request = load_use & ~load_q;

  // Ones digit uses the operand latched at acceptance, not the live A/Cin
  assign ones_sum = SW'(Q0) + SW'(a_q) + SW'(cin_q);
  assign tens_sum = SW'(Q1) + SW'(carry_q);

  assign Busy = (state != IDLE);

  // Accumulator FSM with registered digits and sticky flags
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      load_q  <= 1'b0;
      a_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      Q1      <= '0;
      Q0      <= '0;
      Ovf     <= 1'b0;
      Err     <= 1'b0;
    end else begin
      load_q <= load_use;
      if (clear_use) begin
        // Clear aborts any add in flight and drops a coincident request
        state   <= IDLE;
        carry_q <= 1'b0;
        Q1      <= '0;
        Q0      <= '0;
        Ovf     <= 1'b0;
        Err     <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (request) begin
              if (A > DW'(9)) begin
                Err <= 1'b1;
              end else begin
                a_q   <= A;
                cin_q <= Cin;
                state <= ADD_ONES;
              end
            end
          end
          ADD_ONES: begin
            if (ones_sum > SW'(9)) begin
              Q0      <= DW'(ones_sum - SW'(10));
              carry_q <= 1'b1;
            end else begin
              Q0      <= DW'(ones_sum);
              carry_q <= 1'b0;
            end
            state <= ADD_TENS;
          end
          ADD_TENS: begin
            if (tens_sum == SW'(10)) begin
              Q1  <= '0;
              Ovf <= 1'b1;
            end else begin
              Q1 <= DW'(tens_sum);
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_accumulator.sv
// Self-checking bench for bcd_accumulator: directed scenarios with literal
// expectations plus random Load/Clear/A/Cin traffic checked every cycle
// against a decimal-arithmetic model of the running total.
module tb_bcd_accumulator;

`ifdef BCD_ACC_SYNC_IN_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Load  = 1'b0;
  logic       Clear = 1'b0;
  logic [3:0] A     = 4'd0;
  logic       Cin   = 1'b0;
  logic [3:0] Q1;
  logic [3:0] Q0;
  logic       Busy;
  logic       Ovf;
  logic       Err;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_accumulator dut (
    .Clock(Clock), .Reset(Reset), .Load(Load), .Clear(Clear),
    .A(A), .Cin(Cin), .Q1(Q1), .Q0(Q0), .Busy(Busy), .Ovf(Ovf), .Err(Err)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: total kept as a decimal number; the sum is computed at acceptance
  // and revealed one digit per cycle.
  int m_q1 = 0, m_q0 = 0, m_phase = 0, m_target = 0;
  bit m_ovf = 0, m_err = 0, m_wrap = 0, m_prev = 0;
  bit m_ld_s1 = 0, m_ld_s2 = 0, m_cl_s1 = 0, m_cl_s2 = 0;

  always @(posedge Clock or posedge Reset) begin
    bit ld, cl, req;
    int sum;
    if (Reset) begin
      m_q1 = 0; m_q0 = 0; m_phase = 0; m_target = 0;
      m_ovf = 0; m_err = 0; m_wrap = 0; m_prev = 0;
      m_ld_s1 = 0; m_ld_s2 = 0; m_cl_s1 = 0; m_cl_s2 = 0;
    end else begin
      if (SD == 2) begin
        ld = m_ld_s2; cl = m_cl_s2;
        m_ld_s2 = m_ld_s1; m_ld_s1 = Load;
        m_cl_s2 = m_cl_s1; m_cl_s1 = Clear;
      end else begin
        ld = Load; cl = Clear;
      end
      req = ld && !m_prev;
      m_prev = ld;
      if (cl) begin
        m_q1 = 0; m_q0 = 0; m_ovf = 0; m_err = 0; m_phase = 0;
      end else if (m_phase == 0) begin
        if (req) begin
          if (int'(A) > 9) m_err = 1;
          else begin
            sum = m_q1 * 10 + m_q0 + int'(A) + int'(Cin);
            m_wrap = (sum > 99);
            m_target = sum % 100;
            m_phase = 1;
          end
        end
      end else if (m_phase == 1) begin
        m_q0 = m_target % 10;
        m_phase = 2;
      end else begin
        m_q1 = m_target / 10;
        if (m_wrap) m_ovf = 1;
        m_phase = 0;
      end
    end
  end

  // Per-cycle compare of DUT against model, away from the active edge
  always @(negedge Clock) begin
    if (!Reset) begin
      chk("q1", int'(Q1), m_q1);
      chk("q0", int'(Q0), m_q0);
      chk("busy", int'(Busy), int'(m_phase != 0));
      chk("ovf", int'(Ovf), int'(m_ovf));
      chk("err", int'(Err), int'(m_err));
    end
  end

  function automatic int total();
    return int'(Q1) * 10 + int'(Q0);
  endfunction

  // One Load pulse; counts cycles with Busy high; scrambles A/Cin afterwards
  task automatic add_op(input int a, input int c, output int busy_cyc);
    busy_cyc = 0;
    @(negedge Clock);
    A = 4'(a); Cin = c[0]; Load = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      if (i == 0) begin
        Load = 1'b0;
        A = 4'($urandom_range(0, 9));
        Cin = 1'($urandom_range(0, 1));
      end
      if (Busy) busy_cyc++;
    end
  endtask

  task automatic do_clear();
    @(negedge Clock); Clear = 1'b1;
    @(negedge Clock); Clear = 1'b0;
    repeat (3) @(negedge Clock);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge Clock);
  endtask

  initial begin
    int bc;
    #1;
    chk("reset_q1", int'(Q1), 0);
    chk("reset_q0", int'(Q0), 0);
    chk("reset_busy", int'(Busy), 0);
    chk("reset_ovf", int'(Ovf), 0);
    chk("reset_err", int'(Err), 0);
    wait_neg(2);
    Reset = 1'b0;
    wait_neg(2);

    // 00 + 7 + 0 = 07, with ones-digit latency check
    @(negedge Clock); A = 4'd7; Cin = 1'b0; Load = 1'b1;
    @(negedge Clock); Load = 1'b0; A = 4'd3; Cin = 1'b1;
    wait_neg(SD);
    chk("lat_q0_before", int'(Q0), 0);
    chk("lat_busy", int'(Busy), 1);
    wait_neg(1);
    chk("lat_q0_after", int'(Q0), 7);
    wait_neg(5);
    chk("sum_07", total(), 7);
    add_op(5, 1, bc);
    chk("sum_13", total(), 13);
    chk("busy_cycles", bc, 2);

    // Preload 95, then wrap
    do_clear();
    for (int i = 0; i < 9; i++) add_op(9, 1, bc);
    add_op(5, 0, bc);
    chk("preload_95", total(), 95);
    add_op(9, 1, bc);
    chk("wrap_05", total(), 5);
    chk("wrap_ovf", int'(Ovf), 1);
    add_op(2, 0, bc);
    chk("after_wrap_07", total(), 7);
    chk("ovf_sticky", int'(Ovf), 1);

    // Illegal operand
    add_op(12, 0, bc);
    chk("err_set", int'(Err), 1);
    chk("err_total", total(), 7);
    chk("err_busy_cycles", bc, 0);
    do_clear();
    chk("clear_err", int'(Err), 0);
    chk("clear_total", total(), 0);
    chk("clear_ovf", int'(Ovf), 0);

    // Second rising edge during Busy is ignored
    @(negedge Clock); A = 4'd4; Cin = 1'b0; Load = 1'b1;
    @(negedge Clock); Load = 1'b0;
    @(negedge Clock); Load = 1'b1;
    @(negedge Clock);
    @(negedge Clock); Load = 1'b0;
    wait_neg(6);
    chk("toggle_one_add", total(), 4);

    // Load held high for 10 cycles gives one add
    @(negedge Clock); A = 4'd3; Cin = 1'b0; Load = 1'b1;
    wait_neg(10);
    Load = 1'b0;
    wait_neg(5);
    chk("held_one_add", total(), 7);

    // Clear on the ADD_ONES cycle of 48 + 9
    do_clear();
    for (int i = 0; i < 4; i++) add_op(9, 1, bc);
    add_op(8, 0, bc);
    chk("preload_48", total(), 48);
    @(negedge Clock); A = 4'd9; Cin = 1'b0; Load = 1'b1;
    @(negedge Clock); Load = 1'b0; Clear = 1'b1;
    @(negedge Clock); Clear = 1'b0;
    wait_neg(SD);
    chk("abort_total", total(), 0);
    chk("abort_busy", int'(Busy), 0);
    wait_neg(6);
    chk("abort_no_late_q1", int'(Q1), 0);
    chk("abort_no_late_q0", int'(Q0), 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge Clock);
      Load  = 1'($urandom_range(0, 1));
      Clear = ($urandom_range(0, 24) == 0);
      A     = 4'($urandom_range(0, 11));
      Cin   = 1'($urandom_range(0, 1));
    end
    @(negedge Clock); Load = 1'b0; Clear = 1'b0;
    wait_neg(6);

    // Asynchronous reset in the middle of an add
    add_op(12, 0, bc);
    @(negedge Clock); A = 4'd6; Cin = 1'b1; Load = 1'b1;
    repeat (SD + 2) @(posedge Clock);
    #3 Reset = 1'b1;
    #1;
    chk("areset_q1", int'(Q1), 0);
    chk("areset_q0", int'(Q0), 0);
    chk("areset_busy", int'(Busy), 0);
    chk("areset_ovf", int'(Ovf), 0);
    chk("areset_err", int'(Err), 0);
    @(negedge Clock); Reset = 1'b0; Load = 1'b0;
    wait_neg(6);
    chk("after_reset_total", total(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
